// File: rtl/fsqrt_pkg.sv
// Shared types, exception codes and the square-root arithmetic for the WE=7/WF=7 flopoco word.
package fsqrt_pkg;

  localparam int unsigned FP_WE = 7;
  localparam int unsigned FP_WF = 7;
  localparam int unsigned FP_W  = FP_WE + FP_WF + 3;

  localparam logic [1:0] EXC_ZERO = 2'b00;
  localparam logic [1:0] EXC_NORM = 2'b01;
  localparam logic [1:0] EXC_INF  = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;

  typedef logic [FP_W-1:0] fp_t;

  localparam fp_t NAN_WORD = {EXC_NAN, 1'b0, (FP_WE + FP_WF)'(0)};

  // Restoring integer square root: floor(sqrt(v)) for an 18-bit radicand.
  function automatic logic [8:0] isqrt18(input logic [17:0] v);
    logic [8:0] r;
    logic [8:0] t;
    r = '0;
    for (int i = 8; i >= 0; i--) begin
      t = r | (9'(1) << i);
      if (18'(t) * 18'(t) <= v) r = t;
    end
    return r;
  endfunction

  // Correctly rounded sqrt; the root carries one guard bit and midpoints cannot occur.
  function automatic fp_t fsqrt_eval(input fp_t x);
    logic [1:0]       exc;
    logic             sgn;
    logic [FP_WE-1:0] ex;
    logic [FP_WF-1:0] fr;
    logic [17:0]      rad;
    logic [8:0]       root;
    logic [FP_WF:0]   mant;
    logic [FP_WE-1:0] re;
    fp_t              r;
    {exc, sgn, ex, fr} = x;
    rad  = ex[0] ? {1'b0, 1'b1, fr, 9'b0} : {1'b1, fr, 10'b0};
    root = isqrt18(rad);
    mant = root[8:1] + 8'(root[0]);
    re   = FP_WE'((8'(ex) + 8'd63) >> 1);
    unique case (exc)
      EXC_ZERO: r = {EXC_ZERO, sgn, (FP_WE + FP_WF)'(0)};
      EXC_NORM: r = sgn ? NAN_WORD : {EXC_NORM, 1'b0, re, mant[FP_WF-1:0]};
      EXC_INF:  r = sgn ? NAN_WORD : {EXC_INF, 1'b0, (FP_WE + FP_WF)'(0)};
      default:  r = NAN_WORD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fsqrt_core.sv
// Fixed-latency, unreset fsqrt datapath: result appears LATENCY cycles after X is presented.
module fsqrt_core
  import fsqrt_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic clk,
  input  fp_t  x_i,
  output fp_t  r_o
);

  fp_t pipe_q [LATENCY];

  always_ff @(posedge clk) begin
    pipe_q[0] <= fsqrt_eval(x_i);
    for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign r_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/fsqrt_result_fifo.sv
// Result FIFO with a registered head word; DEPTH must be a power of two >= 2.
module fsqrt_result_fifo
  import fsqrt_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  fp_t                        data_i,
  input  logic                       pop_i,
  output logic                       out_valid_o,
  output fp_t                        out_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fp_t           mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  fp_t           head_q, head_d;

  // Next head is the word the read pointer will land on, taking this cycle's write into account.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push_i) - CW'(pop_i);
    valid_d = (count_d != '0);
    if (count_d == '0)                     head_d = '0;
    else if (push_i && rd_ptr_d == wr_ptr_q) head_d = data_i;
    else                                   head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = head_q;
  assign count_o     = count_q;

endmodule

// File: rtl/fsqrt_issue_ctrl.sv
// Valid/ready front end for the fsqrt core: credit-based issue, valid pipe, result FIFO.
// Optional NaN result counter enabled by `define FSQRT_NAN_CNT_EN.
module fsqrt_issue_ctrl
  import fsqrt_pkg::*;
#(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  fp_t              in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output fp_t              out_data_o,
  output logic             busy_o,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] nan_count_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  logic [LATENCY-1:0] vpipe_q, vpipe_d;
  logic [CW-1:0]      inflight_q, inflight_d, fifo_cnt, fifo_cnt_d;
  logic               in_ready_q, in_ready_d, busy_q, busy_d;
  logic               accept_c, push_c, pop_c;
  fp_t                core_r;

  assign accept_c = in_valid_i && in_ready_q;
  assign push_c   = vpipe_q[LATENCY-1];
  assign pop_c    = out_valid_o && out_ready_i;

  // Credits are granted from next-state counts so in_ready is a plain flop.
  always_comb begin
    vpipe_d    = (vpipe_q << 1) | LATENCY'(accept_c);
    inflight_d = inflight_q + CW'(accept_c) - CW'(push_c);
    fifo_cnt_d = fifo_cnt + CW'(push_c) - CW'(pop_c);
    in_ready_d = (SW'(fifo_cnt_d) + SW'(inflight_d)) < SW'(FIFO_DEPTH);
    busy_d     = (inflight_d != '0) || (fifo_cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe_q    <= '0;
      inflight_q <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      vpipe_q    <= vpipe_d;
      inflight_q <= inflight_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  fsqrt_core #(.LATENCY(LATENCY)) u_core (
    .clk (clk),
    .x_i (in_data_i),
    .r_o (core_r)
  );

  fsqrt_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_c),
    .data_i      (core_r),
    .pop_i       (pop_c),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .count_o     (fifo_cnt)
  );

  assign in_ready_o = in_ready_q;
  assign busy_o     = busy_q;

`ifdef FSQRT_NAN_CNT_EN
  logic [CNT_W-1:0] nan_cnt_q, nan_cnt_d;

  // Saturating count of NaN results landing in the FIFO; clear has priority.
  always_comb begin
    nan_cnt_d = nan_cnt_q;
    if (cnt_clr_i) nan_cnt_d = '0;
    else if (push_c && core_r[FP_W-1 -: 2] == EXC_NAN && nan_cnt_q != '1)
      nan_cnt_d = nan_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nan_cnt_q <= '0;
    else        nan_cnt_q <= nan_cnt_d;
  end

  assign nan_count_o = nan_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr_i;
  assign nan_count_o    = '0;
`endif

endmodule

// File: tb/tb_fsqrt_issue_ctrl.sv
// Directed and randomised checks of fsqrt_issue_ctrl against hand-computed square roots.
`timescale 1ns/1ps
module tb_fsqrt_issue_ctrl;

  localparam int DEPTH = 4;
  localparam int NV    = 12;

  typedef struct {
    logic [16:0] din;
    logic [16:0] dout;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, busy, cnt_clr;
  logic [16:0] in_data, out_data, cur_exp;
  logic [15:0] nan_count;

  vec_t        tbl [NV];
  logic [16:0] exp_q [$];
  int          n_vec = 0, n_err = 0, n_acc = 0, n_pop = 0;
  logic        prev_stall = 1'b0;
  logic [16:0] prev_data = '0;

  always #5 clk = ~clk;

  fsqrt_issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .busy_o      (busy),
    .cnt_clr_i   (cnt_clr),
    .nan_count_o (nan_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Scoreboard: records accepts, checks every pop in order, hold-under-stall and credit bound.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        n_acc++;
      end
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 32'(out_data), 32'h1ffff);
        else chk("order_data", 32'(out_data), 32'(exp_q.pop_front()));
        n_pop++;
      end
      chk("outstanding_le_depth", 32'(exp_q.size() <= DEPTH), 32'd1);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic issue(input logic [16:0] d, input logic [16:0] e);
    @(posedge clk); #2;
    in_valid = 1'b1; in_data = d; cur_exp = e;
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    @(negedge clk);
    for (int k = 0; k < 10 && out_valid !== 1'b1; k++) @(negedge clk);
    chk({nm, "_arrived"}, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_drain(input string nm, input int budget);
    for (int k = 0; k < budget && (exp_q.size() != 0 || busy !== 1'b0); k++) @(negedge clk);
    chk({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int p0, a0, cyc;
    logic stale;
    tbl[0]  = '{17'h0A080, 17'h0A000};  // 4.0 -> 2.0
    tbl[1]  = '{17'h09F80, 17'h09F80};  // 1.0 -> 1.0
    tbl[2]  = '{17'h0A180, 17'h0A080};  // 16.0 -> 4.0
    tbl[3]  = '{17'h0A000, 17'h09FB5};  // 2.0 -> 1.0110101b
    tbl[4]  = '{17'h09E80, 17'h09F00};  // 0.25 -> 0.5
    tbl[5]  = '{17'h0A110, 17'h0A040};  // 9.0 -> 3.0
    tbl[6]  = '{17'h10000, 17'h10000};  // +inf
    tbl[7]  = '{17'h18000, 17'h18000};  // NaN
    tbl[8]  = '{17'h04000, 17'h04000};  // -0
    tbl[9]  = '{17'h00000, 17'h00000};  // +0
    tbl[10] = '{17'h0E080, 17'h18000};  // -4.0 -> NaN
    tbl[11] = '{17'h14000, 17'h18000};  // -inf -> NaN

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; cur_exp = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_nan_count", 32'(nan_count), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Accept at edge E0; result must first be visible after edge E0+2.
    issue(tbl[0].din, tbl[0].dout);
    @(negedge clk); chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(negedge clk); chk("lat_cycle2_valid", 32'(out_valid), 32'd0);
    @(negedge clk); chk("lat_cycle3_valid", 32'(out_valid), 32'd1);
    chk("lat_cycle3_data", 32'(out_data), 32'h0A000);

    for (int i = 0; i < NV; i++) begin
      issue(tbl[i].din, tbl[i].dout);
      wait_valid($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].dout));
    end
    wait_drain("vectors", 20);

    // Burst of 16 with the consumer always ready.
    p0 = n_pop;
    @(posedge clk); #2;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = tbl[i % NV].din; cur_exp = tbl[i % NV].dout;
      @(negedge clk); chk($sformatf("burst_ready%0d", i), 32'(in_ready), 32'd1);
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    wait_drain("burst", 30);
    chk("burst_results", 32'(n_pop - p0), 32'd16);

    // Backpressure: credits run out after exactly DEPTH accepts.
    a0 = n_acc; p0 = n_pop;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = tbl[i + 2].din; cur_exp = tbl[i + 2].dout;
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepts", 32'(n_acc - a0), 32'd4);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_busy", 32'(busy), 32'd1);
    @(posedge clk); #2 out_ready = 1'b1;
    wait_drain("bp", 20);
    chk("bp_results", 32'(n_pop - p0), 32'd4);
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);

    // Exceptions and NaN counting.
`ifdef FSQRT_NAN_CNT_EN
    @(posedge clk); #2 cnt_clr = 1'b1;
    @(posedge clk); #2 cnt_clr = 1'b0;
    @(negedge clk); chk("nan_cleared", 32'(nan_count), 32'd0);
`endif
    issue(17'h1A080, 17'h18000);
    wait_valid("neg_nan");
    chk("neg_nan_top3", 32'(out_data[16:14]), 32'b110);
`ifdef FSQRT_NAN_CNT_EN
    chk("nan_count_one", 32'(nan_count), 32'd1);
    // Clear coincides with the push edge of a NaN result.
    issue(17'h18000, 17'h18000);
    @(posedge clk); #2 cnt_clr = 1'b1;
    @(posedge clk); #2 cnt_clr = 1'b0;
    @(negedge clk); chk("nan_clear_wins", 32'(nan_count), 32'd0);
`endif
    wait_drain("exc", 20);

    // Reset with two ops in flight and two in the FIFO.
    @(posedge clk); #2;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = tbl[i].din; cur_exp = tbl[i].dout;
      @(posedge clk); #2;
    end
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    @(posedge clk); #2 rst_n = 1'b1; out_ready = 1'b1;
    stale = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    chk("midrst_no_stale", 32'(stale), 32'd0);

    // Random valid/ready traffic.
    a0 = n_acc; p0 = n_pop; cyc = 0;
    while (n_acc - a0 < 10000 && cyc < 60000) begin
      int idx;
      idx = $urandom_range(0, NV - 1);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = tbl[idx].din;
      cur_exp   = tbl[idx].dout;
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #2;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_drain("rand", 50);
    chk("rand_accepts", 32'(n_acc - a0), 32'd10000);
    chk("rand_results", 32'(n_pop - p0), 32'd10000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

endmodule
